// File: rtl/bram_sync_fifo.sv
// Single-clock FIFO on an inferred simple-dual-port BRAM with count, almost flags and sticky errors.
// Optional OUTPUT_REG_EN macro adds a second read-data register stage (read latency 2).
module bram_sync_fifo #(
  parameter int WIDTH_DATA    = 48,
  parameter int WIDTH_ADDR    = 8,
  parameter int AFULL_THRESH  = 252,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [WIDTH_DATA-1:0] i_WDATA,
  input  logic                  i_rd_en,
  output logic [WIDTH_DATA-1:0] o_RDATA,
  output logic                  o_rd_valid,
  output logic                  o_full,
  output logic                  o_afull,
  output logic                  o_empty,
  output logic                  o_aempty,
  output logic [WIDTH_ADDR:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_clr_err
);

  localparam int DEPTH = 2 ** WIDTH_ADDR;
  localparam logic [WIDTH_ADDR:0] COUNT_FULL  = {1'b1, {WIDTH_ADDR{1'b0}}};
  localparam logic [WIDTH_ADDR:0] AFULL_LVL   = (WIDTH_ADDR+1)'(AFULL_THRESH);
  localparam logic [WIDTH_ADDR:0] AEMPTY_LVL  = (WIDTH_ADDR+1)'(AEMPTY_THRESH);
  localparam logic [WIDTH_ADDR:0] ONE         = {{WIDTH_ADDR{1'b0}}, 1'b1};
  localparam logic [WIDTH_ADDR:0] ZERO        = '0;

  logic [WIDTH_DATA-1:0] mem [DEPTH];

  logic [WIDTH_ADDR:0]   wr_ptr;
  logic [WIDTH_ADDR:0]   rd_ptr;
  logic [WIDTH_ADDR:0]   count_next;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [WIDTH_DATA-1:0] mem_rdata;
  logic                  mem_rvalid;

  // Accept decisions use the registered flags, so full/empty never look ahead.
  assign wr_acc = i_wr_en & ~o_full;
  assign rd_acc = i_rd_en & ~o_empty;

  always_comb begin
    count_next = o_count;
    if (wr_acc && !rd_acc) count_next = o_count + ONE;
    if (rd_acc && !wr_acc) count_next = o_count - ONE;
  end

  // Memory array carries no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_ptr[WIDTH_ADDR-1:0]] <= i_WDATA;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_count     <= '0;
      o_full      <= 1'b0;
      o_afull     <= 1'b0;
      o_empty     <= 1'b1;
      o_aempty    <= 1'b1;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      o_count     <= count_next;
      o_full      <= (count_next == COUNT_FULL);
      o_afull     <= (count_next >= AFULL_LVL);
      o_empty     <= (count_next == ZERO);
      o_aempty    <= (count_next <= AEMPTY_LVL);
      // A rejected request in the same cycle as a clear keeps the flag set.
      o_overflow  <= (i_wr_en & o_full)  | (o_overflow  & ~i_clr_err);
      o_underflow <= (i_rd_en & o_empty) | (o_underflow & ~i_clr_err);
    end
  end

  // Read never collides with the write address: a write while full is rejected,
  // and a read while empty is rejected, so same-cycle pointers never match.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_rdata  <= '0;
      mem_rvalid <= 1'b0;
    end else begin
      mem_rvalid <= rd_acc;
      if (rd_acc) mem_rdata <= mem[rd_ptr[WIDTH_ADDR-1:0]];
    end
  end

`ifdef OUTPUT_REG_EN
  logic [WIDTH_DATA-1:0] out_rdata;
  logic                  out_rvalid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_rdata  <= '0;
      out_rvalid <= 1'b0;
    end else begin
      out_rvalid <= mem_rvalid;
      if (mem_rvalid) out_rdata <= mem_rdata;
    end
  end

  assign o_RDATA    = out_rdata;
  assign o_rd_valid = out_rvalid;
`else
  assign o_RDATA    = mem_rdata;
  assign o_rd_valid = mem_rvalid;
`endif

endmodule
